// File: rtl/tri_matrix_pkg.sv
// Shared types and constants for the triangular bit-matrix reader.
// Beat-count helpers size the scan for a given row count and width.
package tri_matrix_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_SCAN = 2'd1;
  localparam state_t ST_DONE = 2'd2;

  localparam logic LOWER = 1'b0;
  localparam logic UPPER = 1'b1;

  localparam int ONES_W = 6;

  function automatic int lower_beats(
    input int rows
  );
    return rows * (rows + 1) / 2;
  endfunction

  function automatic int upper_beats(
    input int rows,
    input int width
  );
    int n;
    n = 0;
    for (int i = 0; i < rows; i++) begin
      n += width - i;
    end
    return n;
  endfunction

  localparam int LOWER_BEATS = lower_beats(7);
  localparam int UPPER_BEATS = upper_beats(7, 8);

endpackage

// File: rtl/bit_matrix_regfile.sv
// DEPTH x WIDTH bit matrix: one synchronous row write port,
// synchronous clear, and a combinational single-bit read.
module bit_matrix_regfile #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             we,
  input  logic [3:0]       waddr,
  input  logic [0:WIDTH-1] wdata,
  input  logic [3:0]       rrow,
  input  logic [2:0]       rcol,
  output logic             rbit
);

  logic [0:WIDTH-1] mem_q [DEPTH];
  logic [0:WIDTH-1] mem_d [DEPTH];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (we && (waddr == 4'(i))) begin
        mem_d[i] = wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr) begin
        mem_q[i] <= '0;
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  always_comb begin
    rbit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (rrow == 4'(i)) begin
        rbit = mem_q[i][rcol];
      end
    end
  end

endmodule

// File: rtl/tri_matrix_reader.sv
// Streams a 16x8 bit matrix one bit per beat in lower or upper
// triangular order and reports how many 1-bits went out.
module tri_matrix_reader
  import tri_matrix_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int ROWS  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [0:WIDTH-1]  wr_data,
  output logic              wr_err,
  input  logic              start,
  input  logic              upper,
  output logic              busy,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              dout_bit,
  output logic [3:0]        dout_row,
  output logic [2:0]        dout_col,
  output logic              dout_last,
  output logic              done,
  output logic [ONES_W-1:0] ones_cnt
);

  localparam logic [3:0] LAST_ROW = 4'(ROWS - 1);
  localparam logic [2:0] CMAX     = 3'(WIDTH - 1);
  localparam logic [4:0] DEPTH_L  = 5'(DEPTH);

  state_t state_q, state_d;
  logic   mode_q, mode_d;
  logic [3:0] row_q, row_d;
  logic [2:0] col_q, col_d;
  logic   valid_q, valid_d;
  logic   last_q, last_d;
  logic   bit_q, bit_d;
  logic   busy_q, busy_d;
  logic   done_q, done_d;
  logic   err_q, err_d;
  logic [ONES_W-1:0] cnt_q, cnt_d;

  logic       wr_ok;
  logic       xfer;
  logic [3:0] nrow;
  logic [2:0] ncol;
  logic [3:0] rd_row;
  logic [2:0] rd_col;
  logic       rd_bit;
  logic       rd_val;

  function automatic logic is_last(
    input logic [3:0] r,
    input logic [2:0] c,
    input logic       m
  );
    logic end_col;
    end_col = (m == UPPER) ? (c == CMAX)
                           : ({1'b0, c} == r);
    return (r == LAST_ROW) && end_col;
  endfunction

  // Writes are frozen during a scan so the stream is self-consistent.
  assign wr_ok = wr_en
              && (state_q != ST_SCAN)
              && ({1'b0, wr_addr} < DEPTH_L);
  assign xfer  = valid_q && dout_ready;

  always_comb begin
    nrow = row_q;
    ncol = col_q + 3'd1;
    if (mode_q == UPPER) begin
      if (col_q == CMAX) begin
        nrow = row_q + 4'd1;
        ncol = nrow[2:0];
      end
    end else if ({1'b0, col_q} == row_q) begin
      nrow = row_q + 4'd1;
      ncol = '0;
    end
  end

  assign rd_row = (state_q == ST_SCAN) ? nrow : '0;
  assign rd_col = (state_q == ST_SCAN) ? ncol : '0;

  bit_matrix_regfile #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_regfile (
    .clk   (clk),
    .clr   (rst),
    .we    (wr_ok),
    .waddr (wr_addr),
    .wdata (wr_data),
    .rrow  (rd_row),
    .rcol  (rd_col),
    .rbit  (rd_bit)
  );

  // A write landing with start must be visible on the first beat.
  assign rd_val = (wr_ok && (wr_addr == rd_row))
                ? wr_data[rd_col]
                : rd_bit;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    row_d   = row_q;
    col_d   = col_q;
    valid_d = valid_q;
    last_d  = last_q;
    bit_d   = bit_q;
    cnt_d   = cnt_q;
    err_d   = wr_en && !wr_ok;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          mode_d  = upper;
          row_d   = '0;
          col_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b1;
          last_d  = is_last('0, '0, upper);
          bit_d   = rd_val;
        end
      end
      ST_SCAN: begin
        if (xfer) begin
          cnt_d = cnt_q + {{(ONES_W-1){1'b0}}, bit_q};
          if (last_q) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
            last_d  = 1'b0;
          end else begin
            row_d  = nrow;
            col_d  = ncol;
            last_d = is_last(nrow, ncol, mode_q);
            bit_d  = rd_val;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase
    busy_d = (state_d == ST_SCAN);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= LOWER;
      row_q   <= '0;
      col_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      bit_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      row_q   <= row_d;
      col_q   <= col_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      bit_q   <= bit_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_err     = err_q;
  assign busy       = busy_q;
  assign dout_valid = valid_q;
  assign dout_bit   = bit_q;
  assign dout_row   = row_q;
  assign dout_col   = col_q;
  assign dout_last  = last_q;
  assign done       = done_q;
  assign ones_cnt   = cnt_q;

endmodule

// File: tb/tb_tri_matrix_reader.sv
// Directed bench for tri_matrix_reader with a triangular-order
// reference model and a per-cycle output checker.
module tb_tri_matrix_reader;

  localparam int ROWS  = 7;
  localparam int WIDTH = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [3:0] wr_addr = '0;
  logic [0:7] wr_data = '0;
  logic       wr_err;
  logic       start = 1'b0;
  logic       upper = 1'b0;
  logic       busy;
  logic       dout_valid;
  logic       dout_ready = 1'b0;
  logic       dout_bit;
  logic [3:0] dout_row;
  logic [2:0] dout_col;
  logic       dout_last;
  logic       done;
  logic [5:0] ones_cnt;

  tri_matrix_reader dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_err     (wr_err),
    .start      (start),
    .upper      (upper),
    .busy       (busy),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_bit   (dout_bit),
    .dout_row   (dout_row),
    .dout_col   (dout_col),
    .dout_last  (dout_last),
    .done       (done),
    .ones_cnt   (ones_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  logic [0:7] mdl [16];
  logic [3:0] er [64];
  logic [2:0] ec [64];
  logic       eb [64];
  int exp_n = 0;
  int mones = 0;
  int beat_idx = 0;
  int exp_done_cyc = -1;
  bit checking = 1'b0;
  bit done_seen = 1'b0;

  task automatic chk(input string name,
                     input logic [31:0] got,
                     input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, expv);
    end
  endtask

  // Expected beat list straight from the triangular traversal rule.
  task automatic build_exp(input logic up);
    exp_n = 0;
    mones = 0;
    for (int r = 0; r < ROWS; r++) begin
      int lo, hi;
      lo = up ? r : 0;
      hi = up ? WIDTH - 1 : r;
      for (int c = lo; c <= hi; c++) begin
        er[exp_n] = 4'(r);
        ec[exp_n] = 3'(c);
        eb[exp_n] = mdl[r][c];
        if (mdl[r][c]) mones++;
        exp_n++;
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  busy, 0);
    chk({tag, "_valid"}, dout_valid, 0);
    chk({tag, "_bit"},   dout_bit, 0);
    chk({tag, "_last"},  dout_last, 0);
    chk({tag, "_done"},  done, 0);
    chk({tag, "_wrerr"}, wr_err, 0);
    chk({tag, "_row"},   dout_row, 0);
    chk({tag, "_col"},   dout_col, 0);
    chk({tag, "_ones"},  ones_cnt, 0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [0:7] d);
    wr_en = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
    chk("wr_err_idle", wr_err, 0);
    mdl[a] = d;
  endtask

  task automatic run_scan(input logic up, input bit toggle,
                          input int inj, input bit sw,
                          input logic [0:7] swd,
                          input int lit_n, input int lit_ones,
                          input logic [6:0] lit_last);
    if (sw) mdl[0] = swd;
    build_exp(up);
    chk("model_beats", exp_n, lit_n);
    chk("model_ones", mones, lit_ones);
    chk("model_last", {er[exp_n-1], ec[exp_n-1]}, lit_last);
    beat_idx = 0;
    done_seen = 1'b0;
    checking = 1'b1;
    start = 1'b1;
    upper = up;
    wr_en = sw;
    wr_addr = 4'd0;
    wr_data = swd;
    dout_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    upper = 1'b0;
    wr_en = 1'b0;
    chk("busy_after_start", busy, 1);
    chk("valid_after_start", dout_valid, 1);
    exp_done_cyc = toggle ? cyc + 2 * exp_n - 1 : cyc + exp_n;
    for (int k = 0; k < 400 && !done_seen; k++) begin
      dout_ready = toggle ? (k % 2 == 0) : 1'b1;
      wr_en = (k == inj);
      wr_addr = 4'd2;
      wr_data = 8'h00;
      @(posedge clk); #1;
      wr_en = 1'b0;
      if (inj >= 0 && k == inj) chk("wr_err_pulse", wr_err, 1);
      if (inj >= 0 && k == inj + 1) chk("wr_err_clear", wr_err, 0);
    end
    chk("done_seen", done_seen, 1);
    checking = 1'b0;
    dout_ready = 1'b0;
  endtask

  initial begin
    logic       hold;
    logic [9:0] prev;
    hold = 1'b0;
    prev = '0;
    forever begin
      @(negedge clk);
      if (checking && !rst) begin
        if (hold)
          chk("hold_stable",
              {dout_valid, dout_row, dout_col, dout_bit, dout_last}, prev);
        if (dout_valid) begin
          chk("beat_in_range", beat_idx < exp_n, 1);
          if (beat_idx < exp_n)
            chk($sformatf("beat%0d", beat_idx),
                {dout_row, dout_col, dout_bit, dout_last},
                {er[beat_idx], ec[beat_idx], eb[beat_idx],
                 beat_idx == exp_n - 1});
          if (dout_ready) beat_idx++;
        end
        hold = dout_valid && !dout_ready;
        prev = {dout_valid, dout_row, dout_col, dout_bit, dout_last};
        if (done) begin
          chk("done_beats", beat_idx, exp_n);
          chk("ones_cnt", ones_cnt, mones);
          chk("busy_at_done", busy, 0);
          if (exp_done_cyc >= 0) chk("done_cycle", cyc, exp_done_cyc);
          done_seen = 1'b1;
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    chk_reset("post_reset");

    for (int i = 0; i < ROWS; i++) wr(4'(i), 8'hFF);
    run_scan(1'b0, 1'b0, 3, 1'b0, 8'h00, 28, 28, {4'd6, 3'd6});
    run_scan(1'b1, 1'b0, -1, 1'b0, 8'h00, 35, 35, {4'd6, 3'd7});

    for (int i = 0; i < 16; i++) wr(4'(i), 8'h00);
    wr(4'd3, 8'b1010_0000);
    run_scan(1'b0, 1'b0, -1, 1'b0, 8'h00, 28, 2, {4'd6, 3'd6});
    run_scan(1'b0, 1'b1, -1, 1'b0, 8'h00, 28, 2, {4'd6, 3'd6});
    run_scan(1'b0, 1'b0, -1, 1'b1, 8'h80, 28, 3, {4'd6, 3'd6});

    for (int i = 0; i < ROWS; i++) wr(4'(i), 8'hFF);
    build_exp(1'b0);
    beat_idx = 0;
    done_seen = 1'b0;
    exp_done_cyc = -1;
    checking = 1'b1;
    start = 1'b1;
    upper = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 100 && beat_idx < 10; k++) begin
      dout_ready = 1'b1;
      @(posedge clk); #1;
    end
    chk("reached_beat10", beat_idx, 10);
    checking = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk_reset("rst_mid");
    rst = 1'b0;
    dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) mdl[i] = 8'h00;
    repeat (3) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", done, 0);
    end
    chk("done_not_seen", done_seen, 0);
    run_scan(1'b0, 1'b0, -1, 1'b0, 8'h00, 28, 0, {4'd6, 3'd6});
    run_scan(1'b1, 1'b0, -1, 1'b0, 8'h00, 35, 0, {4'd6, 3'd7});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
